// File: rtl/updn_pkg.sv
// updn_pkg: shared encodings and helpers for the up/down step counter.
// Optional auto-repeat is enabled with `define UPDN_AUTOREPEAT_EN.
package updn_pkg;

  localparam int UPDN_SATURATE = 0;
  localparam int UPDN_WRAP     = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  function automatic int updn_clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/updn_step_counter_if.sv
// Button/lock/clear inputs and count/flag outputs of the step counter.
// master drives buttons and controls; slave is the counter.
interface updn_step_counter_if #(
  parameter int WIDTH = 4
);
  logic             up_c;
  logic             down_c;
  logic             lock_c;
  logic             clr_c;
  logic [WIDTH-1:0] out_c;
  logic             at_max_c;
  logic             at_min_c;
  logic             step_c;

  modport master (
    output up_c, down_c, lock_c, clr_c,
    input  out_c, at_max_c, at_min_c, step_c
  );

  modport slave (
    input  up_c, down_c, lock_c, clr_c,
    output out_c, at_max_c, at_min_c, step_c
  );
endinterface

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop sync + history flop, press pulse, optional repeat.
// Ports: clk_c, reset_n_c, btn_c, [other_c], level_c, pulse_c. Macro UPDN_AUTOREPEAT_EN.
module btn_sync_edge
  import updn_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk_c,
  input  logic reset_n_c,
  input  logic btn_c,
`ifdef UPDN_AUTOREPEAT_EN
  input  logic other_c,
`endif
  output logic level_c,
  output logic pulse_c
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [2:0] vld;
  logic       press;

  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      vld <= 3'b000;
    end else begin
      s1  <= btn_c;
      s2  <= s1;
      s3  <= s2;
      vld <= {vld[1:0], 1'b1};
    end
  end

  // s3 only holds a real sample once vld[2] is set, so a button
  // already held when reset releases is not taken as a press.
  assign press   = s2 & ~s3 & vld[2];
  assign level_c = s2;

`ifdef UPDN_AUTOREPEAT_EN
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = updn_clog2(longint'(TMAX) + 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  rpt_state_e    st_q;
  rpt_state_e    st_d;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic          hold_ok;
  logic          rpt;

  // Both buttons held means neither direction may repeat.
  assign hold_ok = s2 & ~other_c;

  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      st_q  <= IDLE;
      tmr_q <= '0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    unique case (st_q)
      IDLE: begin
        if (press) begin
          st_d  = DELAY;
          tmr_d = '0;
        end
      end
      DELAY: begin
        if (!hold_ok) begin
          st_d = IDLE;
        end else if (tmr_q == HOLD_LAST) begin
          st_d  = REPEAT;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!hold_ok) begin
          st_d = IDLE;
        end else if (tmr_q == REP_LAST) begin
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    rpt = 1'b0;
    unique case (st_q)
      DELAY:   rpt = hold_ok & (tmr_q == HOLD_LAST);
      REPEAT:  rpt = hold_ok & (tmr_q == REP_LAST);
      default: rpt = 1'b0;
    endcase
  end

  assign pulse_c = press | rpt;
`else
  assign pulse_c = press;
`endif

endmodule

// File: rtl/updn_step_counter.sv
// updn_step_counter: button-driven up/down counter, saturate or wrap.
// Ports: clk_c, reset_n_c, bus (slave). Macro UPDN_AUTOREPEAT_EN adds auto-repeat.
module updn_step_counter
  import updn_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 10,
  parameter int RESET_VAL     = 0,
  parameter int WRAP_MODE     = UPDN_SATURATE,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic          clk_c,
  input  logic          reset_n_c,
  updn_step_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
  localparam bit               WRAP  = (WRAP_MODE == UPDN_WRAP);

  logic             up_lvl;
  logic             dn_lvl;
  logic             p_up;
  logic             p_dn;
  logic             go;
  logic             do_up;
  logic             do_dn;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             step_q;

  btn_sync_edge #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_up (
    .clk_c     (clk_c),
    .reset_n_c (reset_n_c),
    .btn_c     (bus.up_c),
`ifdef UPDN_AUTOREPEAT_EN
    .other_c   (dn_lvl),
`endif
    .level_c   (up_lvl),
    .pulse_c   (p_up)
  );

  btn_sync_edge #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_dn (
    .clk_c     (clk_c),
    .reset_n_c (reset_n_c),
    .btn_c     (bus.down_c),
`ifdef UPDN_AUTOREPEAT_EN
    .other_c   (up_lvl),
`endif
    .level_c   (dn_lvl),
    .pulse_c   (p_dn)
  );

`ifndef UPDN_AUTOREPEAT_EN
  logic unused_lvls;
  assign unused_lvls = up_lvl ^ dn_lvl;
`endif

  // Simultaneous up and down cancel; clear beats lock.
  assign go    = ~bus.lock_c & (p_up ^ p_dn);
  assign do_up = ~bus.clr_c & go & p_up;
  assign do_dn = ~bus.clr_c & go & p_dn;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      bus.clr_c: cnt_d = RST_W;
      do_up: begin
        if (cnt_q < MAX_W)
          cnt_d = cnt_q + 1'b1;
        else if (WRAP)
          cnt_d = MIN_W;
      end
      do_dn: begin
        if (cnt_q > MIN_W)
          cnt_d = cnt_q - 1'b1;
        else if (WRAP)
          cnt_d = MAX_W;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_c or negedge reset_n_c) begin
    if (!reset_n_c) begin
      cnt_q  <= RST_W;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= (cnt_d != cnt_q);
    end
  end

  assign bus.out_c    = cnt_q;
  assign bus.step_c   = step_q;
  assign bus.at_max_c = (cnt_q == MAX_W);
  assign bus.at_min_c = (cnt_q == MIN_W);

endmodule

// File: tb/tb_updn_step_counter.sv
// tb_updn_step_counter: saturate and wrap counters vs a behavioural model.
// Repeat behaviour is modelled when UPDN_AUTOREPEAT_EN is defined.
module tb_updn_step_counter;

  localparam int W    = 4;
  localparam int MINV = 0;
  localparam int MAXV = 10;
  localparam int RSTV = 0;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk_c = 1'b0;
  logic rst_n;
  logic up, dn, lock, clr;
  bit   run_chk;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_c = ~clk_c;

  updn_step_counter_if #(.WIDTH(W)) if_s ();
  updn_step_counter_if #(.WIDTH(W)) if_w ();

  assign if_s.up_c   = up;
  assign if_s.down_c = dn;
  assign if_s.lock_c = lock;
  assign if_s.clr_c  = clr;
  assign if_w.up_c   = up;
  assign if_w.down_c = dn;
  assign if_w.lock_c = lock;
  assign if_w.clr_c  = clr;

  updn_step_counter #(
    .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV),
    .WRAP_MODE(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_s (
    .clk_c(clk_c), .reset_n_c(rst_n), .bus(if_s)
  );

  updn_step_counter #(
    .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV),
    .WRAP_MODE(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_w (
    .clk_c(clk_c), .reset_n_c(rst_n), .bus(if_w)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: next value from the stepping rules.
  function automatic int nxt(input int c, input bit wrap, input bit c_clr,
                             input bit c_lock, input bit eu, input bit ed);
    if (c_clr) return RSTV;
    if (c_lock || (eu == ed)) return c;
    if (eu) return (c < MAXV) ? c + 1 : (wrap ? MINV : c);
    return (c > MINV) ? c - 1 : (wrap ? MAXV : c);
  endfunction

  function automatic bit rep_due(input int k);
    return (k >= HOLD) && (((k - HOLD) % REP) == 0);
  endfunction

  int m_cnt [2];
  bit m_stp [2];
  bit uh[$];
  bit dh[$];
  int cyc;
  bit arm_u, arm_d;
  int ep_u, ep_d;

  // Button samples taken at each edge; a press is seen two edges after
  // the first high sample, and only once three post-reset samples exist.
  always @(posedge clk_c or negedge rst_n) begin
    bit pu, pd, lu, ld, eu, ed;
    int nv;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = RSTV;
        m_stp[i] = 1'b0;
      end
      uh.delete();
      dh.delete();
      cyc   = 0;
      arm_u = 1'b0;
      arm_d = 1'b0;
    end else begin
      cyc++;
      uh.push_front(up);
      dh.push_front(dn);
      if (uh.size() > 4) begin
        void'(uh.pop_back());
        void'(dh.pop_back());
      end
      lu = (uh.size() >= 3) ? uh[2] : 1'b0;
      ld = (dh.size() >= 3) ? dh[2] : 1'b0;
      pu = (uh.size() >= 4) ? (uh[2] && !uh[3]) : 1'b0;
      pd = (dh.size() >= 4) ? (dh[2] && !dh[3]) : 1'b0;
      eu = pu;
      ed = pd;
`ifdef UPDN_AUTOREPEAT_EN
      if (pu) begin
        arm_u = 1'b1;
        ep_u  = cyc;
      end else if (arm_u) begin
        if (!lu || ld) arm_u = 1'b0;
        else if (rep_due(cyc - ep_u)) eu = 1'b1;
      end
      if (pd) begin
        arm_d = 1'b1;
        ep_d  = cyc;
      end else if (arm_d) begin
        if (!ld || lu) arm_d = 1'b0;
        else if (rep_due(cyc - ep_d)) ed = 1'b1;
      end
`else
      if (lu && ld) begin
        arm_u = 1'b0;
        arm_d = 1'b0;
      end
`endif
      for (int m = 0; m < 2; m++) begin
        nv       = nxt(m_cnt[m], m == 1, clr, lock, eu, ed);
        m_stp[m] = (nv != m_cnt[m]);
        m_cnt[m] = nv;
      end
    end
  end

  always @(negedge clk_c) begin
    if (run_chk) begin
      chk("sat_out",  int'(if_s.out_c),    m_cnt[0]);
      chk("sat_step", int'(if_s.step_c),   int'(m_stp[0]));
      chk("sat_max",  int'(if_s.at_max_c), int'(m_cnt[0] == MAXV));
      chk("sat_min",  int'(if_s.at_min_c), int'(m_cnt[0] == MINV));
      chk("wrp_out",  int'(if_w.out_c),    m_cnt[1]);
      chk("wrp_step", int'(if_w.step_c),   int'(m_stp[1]));
      chk("wrp_max",  int'(if_w.at_max_c), int'(m_cnt[1] == MAXV));
      chk("wrp_min",  int'(if_w.at_min_c), int'(m_cnt[1] == MINV));
    end
  end

  task automatic press(input bit pu_, input bit pd_,
                       input int hold, input int gap);
    up = pu_;
    dn = pd_;
    repeat (hold) @(negedge clk_c);
    up = 1'b0;
    dn = 1'b0;
    repeat (gap) @(negedge clk_c);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk_c);
    clr = 1'b0;
    repeat (2) @(negedge clk_c);
  endtask

  initial begin
    rst_n   = 1'b0;
    up      = 1'b0;
    dn      = 1'b0;
    lock    = 1'b0;
    clr     = 1'b0;
    run_chk = 1'b0;
    repeat (3) @(negedge clk_c);
    run_chk = 1'b1;
    chk("rst_out", int'(if_s.out_c), RSTV);
    chk("rst_min", int'(if_s.at_min_c), 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_c);

    // Single 3-clock press: value changes at the third sampling edge.
    up = 1'b1;
    @(negedge clk_c);
    @(negedge clk_c);
    chk("lat_before", int'(if_s.out_c), 0);
    @(negedge clk_c);
    up = 1'b0;
    chk("lat_out", int'(if_s.out_c), 1);
    chk("lat_step", int'(if_s.step_c), 1);
    @(negedge clk_c);
    chk("lat_step_end", int'(if_s.step_c), 0);
    repeat (3) @(negedge clk_c);

    // Saturation at the top, then one step back.
    repeat (12) press(1'b1, 1'b0, 3, 4);
    chk("sat_top", int'(if_s.out_c), 10);
    chk("sat_top_flag", int'(if_s.at_max_c), 1);
    press(1'b0, 1'b1, 3, 4);
    chk("sat_down", int'(if_s.out_c), 9);

    // Wrap in both directions from the top.
    do_clr();
    repeat (10) press(1'b1, 1'b0, 3, 4);
    chk("wrp_at10", int'(if_w.out_c), 10);
    press(1'b1, 1'b0, 3, 4);
    chk("wrp_up", int'(if_w.out_c), 0);
    chk("sat_hold", int'(if_s.out_c), 10);
    press(1'b0, 1'b1, 3, 4);
    chk("wrp_down", int'(if_w.out_c), 10);

    // Simultaneous presses cancel; locked press is lost.
    do_clr();
    repeat (5) press(1'b1, 1'b0, 3, 4);
    press(1'b1, 1'b1, 3, 5);
    chk("both_cancel", int'(if_s.out_c), 5);
    lock = 1'b1;
    up   = 1'b1;
    repeat (4) @(negedge clk_c);
    lock = 1'b0;
    repeat (3) @(negedge clk_c);
    up = 1'b0;
    repeat (4) @(negedge clk_c);
    chk("lock_lost", int'(if_s.out_c), 5);

    // Clear from 7, then reset mid-press with the button kept held.
    repeat (2) press(1'b1, 1'b0, 3, 4);
    chk("at7", int'(if_s.out_c), 7);
    clr = 1'b1;
    @(negedge clk_c);
    clr = 1'b0;
    chk("clr_out", int'(if_s.out_c), 0);
    chk("clr_step", int'(if_s.step_c), 1);
    repeat (3) press(1'b1, 1'b0, 3, 4);
    up = 1'b1;
    @(negedge clk_c);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", int'(if_s.out_c), 0);
    @(negedge clk_c);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_c);
    chk("rst_held", int'(if_s.out_c), 0);
    up = 1'b0;
    repeat (4) @(negedge clk_c);

`ifdef UPDN_AUTOREPEAT_EN
    do_clr();
    up = 1'b1;
    repeat (20) @(negedge clk_c);
    up = 1'b0;
    repeat (6) @(negedge clk_c);
    chk("auto_rep", int'(if_s.out_c), 4);
`endif

    // Randomised levels, lock, clear and one reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) up = ~up;
      if ($urandom_range(0, 7) == 0) dn = ~dn;
      lock = ($urandom_range(0, 15) == 0);
      clr  = ($urandom_range(0, 60) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk_c);
    end
    up   = 1'b0;
    dn   = 1'b0;
    lock = 1'b0;
    clr  = 1'b0;
    repeat (5) @(negedge clk_c);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
